ff_bank_arbiter: RTL
====================

# ff_bank_arbiter

Shared flip-flop bank controller for the sequential/ff_converstion group. It owns a WIDTH-bit register bank built from SR storage cells and shares it between two requesters through round-robin arbitration. Each granted command is converted to per-bit S/R drive according to its mode (SR, JK, D or T), applied in one cycle, and acknowledged. Illegal SR drive is detected and reported.

## Interface
- WIDTH, 4, bank width in bits
- CNT_W, 8, width of the completed-operation counter
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A command valid; held until gnt_a
- mode_a  input  2  A mode: 00 SR, 01 JK, 10 D, 11 T
- x_a  input  WIDTH  A operand X (S / J / D / T per mode)
- y_a  input  WIDTH  A operand Y (R / K; ignored in D and T)
- req_b, mode_b, x_b, y_b  input  1/2/WIDTH/WIDTH  requester B, same meaning
- err_clr  input  1  clears err
- gnt_a  output  1  one-cycle grant pulse to A
- gnt_b  output  1  one-cycle grant pulse to B
- q_out  output  WIDTH  bank contents
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle pulse: q_out reflects the completed command
- err  output  1  sticky illegal-SR flag
- op_cnt  output  CNT_W  completed commands, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE to EXEC when req_a or req_b is high.
  - EXEC to DONE unconditionally.
  - DONE to IDLE unconditionally.
- Arbitration happens only in IDLE.
  - Only one request high: that requester wins.
  - Both high: the requester not granted last wins.
  - last_grant resets to B, so A wins first after reset.
- On the IDLE to EXEC edge:
  - The winner's mode, x and y are latched into cmd registers.
  - last_grant is updated.
  - The winner's gnt is registered high for the EXEC cycle.
- Requests arriving during EXEC or DONE are not sampled. A requester drops req after its gnt. The loser keeps its req high and is served in the next IDLE.
- In EXEC, per bit i, using latched cmd and current q:
  - SR: S=x, R=y.
  - JK: S=x&~q, R=y&q.
  - D: S=x, R=~x.
  - T: S=x&~q, R=x&q.
- Cell update at the end of EXEC, per bit:
  - S=1, R=0: q becomes 1.
  - S=0, R=1: q becomes 0.
  - S=0, R=0: hold.
  - S=1, R=1: hold, and err is set. This can occur only in SR mode.
- At the end of EXEC: done is registered high for the DONE cycle and op_cnt increments.
- err:
  - Set by an illegal SR bit; cleared by err_clr.
  - Set and clear in the same cycle: set wins.
  - err never blocks operation.

## Timing
- Reset, all applied on the next rising edge:
  - state=IDLE, q_out=0, gnt_a=gnt_b=0, done=0, busy=0, err=0, op_cnt=0, last_grant=B.
  - The cmd registers are also cleared.
- Latency and throughput:
  - req sampled in IDLE at edge n.
  - gnt and busy high in cycle n+1 (EXEC).
  - q_out updated and done high in cycle n+2 (DONE).
  - IDLE again in cycle n+3.
  - Throughput is one command per 3 cycles.
- Back-to-back: a held loser request is granted at edge n+3, with gnt in cycle n+4.
- Reset mid-operation (in EXEC or DONE) aborts the command:
  - The pending q update is discarded, no done pulse occurs and op_cnt does not increment.
  - All outputs take their reset values.
- op_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Outputs are all registered; none depends combinationally on the inputs.

## Test plan
- Reset: assert rst 2 cycles with req_a=1 -> q_out=0000, gnt_a=gnt_b=0, done=0, busy=0, err=0, op_cnt=0; after release, A is granted on the first IDLE.
- JK set/toggle: A, JK, x=1111, y=0000 -> done with q_out=1111; then JK, x=y=1111 -> q_out=0000; op_cnt=2.
- Round-robin: req_a=req_b=1 held from reset -> gnt_a first, then gnt_b 3 cycles later; again both high -> A is granted (B was last).
- Illegal SR: from q=0000, SR, x=1010, y=1001 -> q_out=0010, err=1 from the DONE cycle onward. Then err_clr and an illegal command in the same cycle -> err stays 1. err_clr alone -> err=0.
- D/T modes: from q=0010, T, x=0101 -> q_out=0111; then D, x=1100, y=1111 -> q_out=1100, err unchanged.
- Abort: grant a JK x=1111 command from q=0000, assert rst in the EXEC cycle -> q_out stays 0000, no done pulse, op_cnt=0; wrap check with CNT_W=2: 4 commands -> op_cnt=0.

Source files
------------

// File: rtl/ff_bank_arbiter.sv
// Shared SR-cell register bank with two round-robin arbitrated requesters.
// Each granted command (SR/JK/D/T) is converted to S/R drive and applied in one EXEC cycle.
module ff_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       mode_a,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] y_a,
  input  logic             req_b,
  input  logic [1:0]       mode_b,
  input  logic [WIDTH-1:0] x_b,
  input  logic [WIDTH-1:0] y_b,
  input  logic             err_clr,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] q_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  state_t             state_q, state_d;
  logic               last_b_q, last_b_d;   // 1: B was granted last
  logic [1:0]         cmd_mode_q, cmd_mode_d;
  logic [WIDTH-1:0]   cmd_x_q, cmd_x_d;
  logic [WIDTH-1:0]   cmd_y_q, cmd_y_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_drv, r_drv;
  logic               pick_a;

  // Per-bit S/R drive derived from the latched command and the current bank.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    s_drv = '0;
    r_drv = '0;
    unique case (cmd_mode_q)
      MODE_SR: begin s_drv = cmd_x_q;          r_drv = cmd_y_q;         end
      MODE_JK: begin s_drv = cmd_x_q & ~q_q;   r_drv = cmd_y_q & q_q;   end
      MODE_D:  begin s_drv = cmd_x_q;          r_drv = ~cmd_x_q;        end
      MODE_T:  begin s_drv = cmd_x_q & ~q_q;   r_drv = cmd_x_q & q_q;   end
      default: begin s_drv = '0;               r_drv = '0;              end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    cmd_mode_d = cmd_mode_q;
    cmd_x_d    = cmd_x_q;
    cmd_y_d    = cmd_y_q;
    q_d        = q_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q & ~err_clr;
    cnt_d      = cnt_q;
    pick_a     = req_a & (~req_b | last_b_q);

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = EXEC;
          if (pick_a) begin
            gnt_a_d    = 1'b1;
            last_b_d   = 1'b0;
            cmd_mode_d = mode_a;
            cmd_x_d    = x_a;
            cmd_y_d    = y_a;
          end else begin
            gnt_b_d    = 1'b1;
            last_b_d   = 1'b1;
            cmd_mode_d = mode_b;
            cmd_x_d    = x_b;
            cmd_y_d    = y_b;
          end
        end
      end
      EXEC: begin
        // Set-only bits go high, reset-only bits go low, S=R bits hold.
        q_d     = (s_drv & ~r_drv) | (q_q & ~(s_drv ^ r_drv));
        if (|(s_drv & r_drv)) err_d = 1'b1;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      cmd_mode_q <= '0;
      cmd_x_q    <= '0;
      cmd_y_q    <= '0;
      q_q        <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      cmd_mode_q <= cmd_mode_d;
      cmd_x_q    <= cmd_x_d;
      cmd_y_q    <= cmd_y_d;
      q_q        <= q_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign q_out  = q_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign op_cnt = cnt_q;

endmodule
